// File: rtl/pipeline_fetch_q.sv
// Fetch stage: owns the PC, issues sequential reads to a synchronous IM and buffers
// returned words in a small FIFO ahead of DECODE, with redirect flush and stall hold.
module pipeline_fetch_q #(
  parameter int          QUEUE_DEPTH = 4,
  parameter int          STALL_W     = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               br_late_enable,
  input  logic [31:0]        br_target,
  input  logic               early_br_enable,
  input  logic [31:0]        early_br_target,
  input  logic [STALL_W-1:0] stall_request,
  output logic               im_req,
  output logic [31:0]        im_addr,
  input  logic [31:0]        im_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        pc_out,
  output logic [31:0]        inst_out,
  output logic               br_late_done_d1
);

  localparam int            PW      = $clog2(QUEUE_DEPTH);
  localparam int            CW      = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(QUEUE_DEPTH);

  logic [31:0]        fetch_pc;
  logic [31:0]        req_pc;
  logic [31:0]        q_pc   [QUEUE_DEPTH];
  logic [31:0]        q_inst [QUEUE_DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic               inflight;
  logic               drop_next;
  logic               first_cycle;
  logic [STALL_W-1:0] stall_counter;

  logic               redirect;
  logic [31:0]        redirect_target;
  logic [CW:0]        occupancy;
  logic               issue;
  logic               stall_load;
  logic               fetch_stall;
  logic               push;
  logic               pop;

  always_comb begin
    redirect        = br_late_enable | early_br_enable;
    redirect_target = br_late_enable ? br_target : early_br_target;
    // Counting the in-flight word guarantees a slot for it when it returns.
    occupancy       = {1'b0, count} + {{CW{1'b0}}, inflight};
    issue           = !rst && !redirect && (occupancy < DEPTH_C);
    stall_load      = !first_cycle && (stall_request != '0);
    fetch_stall     = stall_load || (stall_counter != '0);
    push            = inflight && !drop_next && !redirect;
    out_valid       = (count != '0) && !fetch_stall;
    pop             = out_valid && out_ready && !redirect;
    im_req          = issue;
    im_addr         = fetch_pc;
    pc_out          = out_valid ? q_pc[rd_ptr]   : 32'h0;
    inst_out        = out_valid ? q_inst[rd_ptr] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc        <= RESET_PC;
      req_pc          <= RESET_PC;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      inflight        <= 1'b0;
      drop_next       <= 1'b0;
      stall_counter   <= '0;
      first_cycle     <= 1'b1;
      br_late_done_d1 <= 1'b0;
    end else begin
      first_cycle     <= 1'b0;
      br_late_done_d1 <= br_late_enable;
      inflight        <= issue;
      drop_next       <= redirect & inflight;

      if (redirect)   fetch_pc <= redirect_target;
      else if (issue) fetch_pc <= fetch_pc + 32'd4;
      if (issue)      req_pc   <= fetch_pc;

      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (!push && pop) count <= count - CW'(1);
      end

      // A new request restarts the hold even if one is already counting down.
      if (stall_load)                stall_counter <= stall_request - STALL_W'(1);
      else if (stall_counter != '0)  stall_counter <= stall_counter - STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= req_pc;
      q_inst[wr_ptr] <= im_rdata;
    end
  end

endmodule

// File: tb/tb_pipeline_fetch_q.sv
// Bench for pipeline_fetch_q: directed cycle table, redirect/stall/reset sequences,
// then randomized traffic scored against an in-order program-stream model.
module tb_pipeline_fetch_q;

  localparam int          QUEUE_DEPTH = 4;
  localparam int          STALL_W     = 2;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] KEY         = 32'hA5A5_0000;

  logic               clk;
  logic               rst;
  logic               br_late_enable;
  logic [31:0]        br_target;
  logic               early_br_enable;
  logic [31:0]        early_br_target;
  logic [STALL_W-1:0] stall_request;
  logic               im_req;
  logic [31:0]        im_addr;
  logic [31:0]        im_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        pc_out;
  logic [31:0]        inst_out;
  logic               br_late_done_d1;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_fetch_q #(
    .QUEUE_DEPTH(QUEUE_DEPTH),
    .STALL_W    (STALL_W),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .br_late_enable (br_late_enable),
    .br_target      (br_target),
    .early_br_enable(early_br_enable),
    .early_br_target(early_br_target),
    .stall_request  (stall_request),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_rdata       (im_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pc_out         (pc_out),
    .inst_out       (inst_out),
    .br_late_done_d1(br_late_done_d1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory; non-requested cycles return junk.
  always @(posedge clk) begin
    if (im_req) im_rdata <= im_addr ^ KEY;
    else        im_rdata <= 32'hDEAD_BEEF;
  end

  typedef struct {
    logic               rdy;
    logic [STALL_W-1:0] st;
    logic               ov;
    logic [31:0]        pc;
    logic               req;
    logic [31:0]        addr;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic rdy, input logic [STALL_W-1:0] st, input logic ov,
                              input logic [31:0] pc, input logic req, input logic [31:0] addr);
    vec_t v;
    v.rdy = rdy; v.st = st; v.ov = ov; v.pc = pc; v.req = req; v.addr = addr;
    return v;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
    return {t[31:2], 2'b00};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic ov, input logic [31:0] pc);
    chk({nm, "_valid"}, {31'b0, out_valid}, {31'b0, ov});
    if (ov) begin
      chk({nm, "_pc"}, pc_out, pc);
      chk({nm, "_inst"}, inst_out, pc ^ KEY);
    end else begin
      chk({nm, "_inst_nop"}, inst_out, 32'h0);
    end
  endtask

  task automatic drive(input logic rdy, input logic [STALL_W-1:0] st, input logic late,
                       input logic [31:0] lt, input logic early, input logic [31:0] et);
    @(negedge clk);
    rst             = 1'b0;
    out_ready       = rdy;
    stall_request   = st;
    br_late_enable  = late;
    br_target       = lt;
    early_br_enable = early;
    early_br_target = et;
    #1;
  endtask

  task automatic idle();
    drive(1'b1, '0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rst             = 1'b1;
      out_ready       = 1'b1;
      stall_request   = '0;
      br_late_enable  = 1'b0;
      early_br_enable = 1'b0;
    end
    #1;
  endtask

  initial begin
    int          last_redir;
    int          stall_end;
    logic [31:0] exp_pc;
    logic        prev_late;
    logic        rdy, late, early;
    logic [STALL_W-1:0] st;
    logic [31:0] lt, et;

    rst = 1'b1; out_ready = 1'b1; stall_request = '0;
    br_late_enable = 1'b0; br_target = 32'h0;
    early_br_enable = 1'b0; early_br_target = 32'h0;

    vecs[0] = mk(1'b1, 2'd3, 1'b0, 32'h0,  1'b1, 32'h0);
    vecs[1] = mk(1'b1, 2'd0, 1'b0, 32'h0,  1'b1, 32'h4);
    vecs[2] = mk(1'b1, 2'd0, 1'b1, 32'h0,  1'b1, 32'h8);
    vecs[3] = mk(1'b1, 2'd0, 1'b1, 32'h4,  1'b1, 32'hC);
    vecs[4] = mk(1'b1, 2'd0, 1'b1, 32'h8,  1'b1, 32'h10);
    vecs[5] = mk(1'b1, 2'd3, 1'b0, 32'h0,  1'b1, 32'h14);
    vecs[6] = mk(1'b1, 2'd0, 1'b0, 32'h0,  1'b1, 32'h18);
    vecs[7] = mk(1'b1, 2'd0, 1'b0, 32'h0,  1'b0, 32'h0);
    for (int i = 8; i < 18; i++) vecs[i] = mk(1'b0, 2'd0, 1'b1, 32'hC, 1'b0, 32'h0);
    vecs[18] = mk(1'b1, 2'd0, 1'b1, 32'hC,  1'b0, 32'h0);
    vecs[19] = mk(1'b1, 2'd0, 1'b1, 32'h10, 1'b1, 32'h1C);
    vecs[20] = mk(1'b1, 2'd0, 1'b1, 32'h14, 1'b1, 32'h20);
    vecs[21] = mk(1'b1, 2'd0, 1'b1, 32'h18, 1'b1, 32'h24);
    vecs[22] = mk(1'b1, 2'd0, 1'b1, 32'h1C, 1'b1, 32'h28);
    vecs[23] = mk(1'b1, 2'd0, 1'b1, 32'h20, 1'b1, 32'h2C);

    do_reset(2);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_im_req", {31'b0, im_req}, 32'h0);
    chk("rst_done", {31'b0, br_late_done_d1}, 32'h0);

    // Cycle table: streaming, first-cycle stall ignored, 3-cycle stall, 10-cycle backpressure.
    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].st, 1'b0, 32'h0, 1'b0, 32'h0);
      expect_out($sformatf("tbl%0d", i + 1), vecs[i].ov, vecs[i].pc);
      chk($sformatf("tbl%0d_im_req", i + 1), {31'b0, im_req}, {31'b0, vecs[i].req});
      if (vecs[i].req) chk($sformatf("tbl%0d_im_addr", i + 1), im_addr, vecs[i].addr);
    end

    // Late redirect with a word in flight and entries queued.
    drive(1'b1, '0, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("late_T_im_req", {31'b0, im_req}, 32'h0);
    idle(); expect_out("late_T1", 1'b0, 32'h0);
    chk("late_T1_done", {31'b0, br_late_done_d1}, 32'h1);
    chk("late_T1_addr", im_addr, 32'h100);
    idle(); expect_out("late_T2", 1'b0, 32'h0);
    chk("late_T2_done", {31'b0, br_late_done_d1}, 32'h0);
    chk("late_T2_addr", im_addr, 32'h104);
    idle(); expect_out("late_T3", 1'b1, 32'h100);
    idle(); expect_out("late_T4", 1'b1, 32'h104);

    // Late redirect wins over a simultaneous early one.
    drive(1'b1, '0, 1'b1, 32'h300, 1'b1, 32'h200);
    chk("prio_T_im_req", {31'b0, im_req}, 32'h0);
    idle(); chk("prio_T1_addr", im_addr, 32'h300);
    chk("prio_T1_done", {31'b0, br_late_done_d1}, 32'h1);
    idle(); expect_out("prio_T2", 1'b0, 32'h0);
    idle(); expect_out("prio_T3", 1'b1, 32'h300);

    // Early redirect alone.
    drive(1'b1, '0, 1'b0, 32'h0, 1'b1, 32'h200);
    idle(); chk("early_T1_addr", im_addr, 32'h200);
    chk("early_T1_done", {31'b0, br_late_done_d1}, 32'h0);
    expect_out("early_T1", 1'b0, 32'h0);
    idle(); expect_out("early_T2", 1'b0, 32'h0);
    idle(); expect_out("early_T3", 1'b1, 32'h200);
    idle(); expect_out("early_T4", 1'b1, 32'h204);

    // Redirect and stall in the same cycle.
    drive(1'b1, 2'd3, 1'b1, 32'h400, 1'b0, 32'h0);
    expect_out("rs_T0", 1'b0, 32'h0);
    idle(); expect_out("rs_T1", 1'b0, 32'h0);
    idle(); expect_out("rs_T2", 1'b0, 32'h0);
    idle(); expect_out("rs_T3", 1'b1, 32'h400);
    idle(); expect_out("rs_T4", 1'b1, 32'h404);

    // Reset while the queue holds entries and a word is in flight.
    drive(1'b0, '0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, '0, 1'b0, 32'h0, 1'b0, 32'h0);
    do_reset(1);
    chk("mrst_im_req", {31'b0, im_req}, 32'h0);
    idle(); expect_out("mrst_R1", 1'b0, 32'h0);
    chk("mrst_R1_pc", pc_out, 32'h0);
    chk("mrst_R1_done", {31'b0, br_late_done_d1}, 32'h0);
    chk("mrst_R1_im_req", {31'b0, im_req}, 32'h1);
    chk("mrst_R1_addr", im_addr, RESET_PC);
    idle(); chk("mrst_R2_addr", im_addr, RESET_PC + 32'd4);
    expect_out("mrst_R2", 1'b0, 32'h0);
    idle(); expect_out("mrst_R3", 1'b1, RESET_PC);
    idle(); expect_out("mrst_R4", 1'b1, RESET_PC + 32'd4);

    // Randomized traffic: the output stream must be the program order implied by
    // the redirects, with flush bubbles and stall windows where the rules put them.
    do_reset(2);
    exp_pc     = RESET_PC;
    last_redir = -100;
    stall_end  = -100;
    prev_late  = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      st    = ($urandom_range(0, 15) == 0) ? STALL_W'($urandom_range(1, 3)) : '0;
      late  = ($urandom_range(0, 23) == 0);
      early = ($urandom_range(0, 23) == 0);
      lt    = pick_target();
      et    = pick_target();
      drive(rdy, st, late, lt, early, et);

      if (st != '0 && c > 1) stall_end = c + int'(st) - 1;
      chk("rnd_done", {31'b0, br_late_done_d1}, {31'b0, prev_late});
      if (late || early) chk("rnd_req_on_redirect", {31'b0, im_req}, 32'h0);
      if (!out_valid) chk("rnd_inst_nop", inst_out, 32'h0);
      if (c <= stall_end) chk("rnd_stall", {31'b0, out_valid}, 32'h0);
      else if (c - last_redir >= 3 && c >= 3) chk("rnd_live", {31'b0, out_valid}, 32'h1);
      if (c - last_redir == 1 || c - last_redir == 2)
        chk("rnd_flush", {31'b0, out_valid}, 32'h0);
      if (out_valid) begin
        chk("rnd_pc", pc_out, exp_pc);
        chk("rnd_inst", inst_out, exp_pc ^ KEY);
      end

      if (late || early) begin
        exp_pc     = late ? lt : et;
        last_redir = c;
      end else if (out_valid && rdy) begin
        exp_pc = exp_pc + 32'd4;
      end
      prev_late = late;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
